// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one read per instruction over a req/gnt/rvalid bus and hands
// the returned word with its PC to the core on a valid/ready handshake. Errors are sticky until
// reset.
module inst_fetch #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned INST_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [INST_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  inst_valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] inst_pc_o,
    input  logic                  inst_ready_i,
    output logic                  fetch_err_o,
    output logic [1:0]            err_cause_o
);

    localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CauseBus     = 2'd1;
    localparam logic [1:0] CauseAlign   = 2'd2;
    localparam logic [1:0] CauseTimeout = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StErr
    } state_e;

    state_e              state_q;
    logic [TimerW-1:0]   timer_q;
    // Set when the outstanding response belongs to a flushed fetch and must be discarded.
    logic                drop_q;

    // FSM with all outputs registered; mem_addr_o doubles as the latched fetch PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            drop_q       <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            fetch_err_o  <= 1'b0;
            err_cause_o  <= 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_i && !flush_i) begin
                        if (pc_i[1:0] != 2'b00) begin
                            state_q     <= StErr;
                            fetch_err_o <= 1'b1;
                            err_cause_o <= CauseAlign;
                        end else begin
                            state_q    <= StReq;
                            mem_addr_o <= pc_i;
                            mem_req_o  <= 1'b1;
                        end
                    end
                end

                StReq: begin
                    if (mem_gnt_i) begin
                        // A flush racing the grant still leaves a response to absorb.
                        state_q   <= StWait;
                        mem_req_o <= 1'b0;
                        timer_q   <= '0;
                        drop_q    <= flush_i;
                    end else if (flush_i) begin
                        state_q   <= StIdle;
                        mem_req_o <= 1'b0;
                    end
                end

                StWait: begin
                    if (mem_rvalid_i) begin
                        drop_q <= 1'b0;
                        if (mem_err_i) begin
                            state_q     <= StErr;
                            fetch_err_o <= 1'b1;
                            err_cause_o <= CauseBus;
                        end else if (drop_q || flush_i) begin
                            state_q <= StIdle;
                        end else begin
                            state_q      <= StHold;
                            inst_o       <= mem_rdata_i;
                            inst_pc_o    <= mem_addr_o;
                            inst_valid_o <= 1'b1;
                        end
                    end else begin
                        if (flush_i) begin
                            drop_q <= 1'b1;
                        end
                        if (timer_q == TimerLast) begin
                            state_q     <= StErr;
                            fetch_err_o <= 1'b1;
                            err_cause_o <= CauseTimeout;
                        end else begin
                            timer_q <= timer_q + TimerW'(1);
                        end
                    end
                end

                StHold: begin
                    if (flush_i) begin
                        state_q      <= StIdle;
                        inst_valid_o <= 1'b0;
                    end else if (inst_ready_i) begin
                        inst_valid_o <= 1'b0;
                        if (!en_i) begin
                            state_q <= StIdle;
                        end else if (pc_i[1:0] != 2'b00) begin
                            state_q     <= StErr;
                            fetch_err_o <= 1'b1;
                            err_cause_o <= CauseAlign;
                        end else begin
                            state_q    <= StReq;
                            mem_addr_o <= pc_i;
                            mem_req_o  <= 1'b1;
                        end
                    end
                end

                StErr: begin
                    // Terminal until reset.
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal checks plus a transaction-level
// scoreboard model compared against the DUT outputs every cycle.
module tb_inst_fetch;

    localparam int DW = 64;
    localparam int IW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst, en, flush, gnt, rvalid, merr, ready;
    logic [DW-1:0] pc;
    logic [IW-1:0] rdata;

    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic [DW-1:0] inst_pc;
    logic          fetch_err;
    logic [1:0]    err_cause;

    always #5 clk = ~clk;

    inst_fetch #(
        .DATA_WIDTH    (DW),
        .INST_WIDTH    (IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .flush_i     (flush),
        .pc_i        (pc),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_gnt_i   (gnt),
        .mem_rvalid_i(rvalid),
        .mem_rdata_i (rdata),
        .mem_err_i   (merr),
        .inst_valid_o(inst_valid),
        .inst_o      (inst),
        .inst_pc_o   (inst_pc),
        .inst_ready_i(ready),
        .fetch_err_o (fetch_err),
        .err_cause_o (err_cause)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // pending: a request is being presented; outstanding: granted, response awaited;
    // the queues hold the instruction currently offered to the core.
    logic          m_pend, m_out, m_drop, m_free, m_on;
    logic [DW-1:0] m_addr;
    int            m_cnt;
    logic [1:0]    m_cause;
    logic [DW-1:0] q_pc[$];
    logic [IW-1:0] q_data[$];

    task automatic start_fetch();
        if (pc[1:0] != 2'b00) m_cause = 2'd2;
        else begin
            m_pend = 1'b1;
            m_addr = pc;
        end
    endtask

    initial begin
        m_on = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_on = 1'b1; m_pend = 1'b0; m_out = 1'b0; m_drop = 1'b0;
                m_cnt = 0; m_cause = 2'd0; m_addr = '0;
                q_pc.delete(); q_data.delete();
            end else if (m_on && m_cause == 2'd0) begin
                m_free = !m_pend && !m_out && q_pc.size() == 0;
                if (m_free) begin
                    if (en && !flush) start_fetch();
                end else if (m_pend) begin
                    if (gnt) begin
                        m_pend = 1'b0; m_out = 1'b1; m_drop = flush; m_cnt = 0;
                    end else if (flush) m_pend = 1'b0;
                end else if (m_out) begin
                    if (rvalid) begin
                        m_out = 1'b0;
                        if (merr) m_cause = 2'd1;
                        else if (!(m_drop || flush)) begin
                            q_pc.push_back(m_addr);
                            q_data.push_back(rdata);
                        end
                    end else begin
                        if (flush) m_drop = 1'b1;
                        m_cnt++;
                        if (m_cnt == TO) begin
                            m_cause = 2'd3;
                            m_out = 1'b0;
                        end
                    end
                end else begin
                    if (flush || ready) begin
                        void'(q_pc.pop_front());
                        void'(q_data.pop_front());
                    end
                    if (!flush && ready && en) start_fetch();
                end
            end
        end
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            check("m_req", mem_req, m_pend && m_cause == 2'd0);
            if (m_pend && m_cause == 2'd0) check("m_addr", mem_addr, m_addr);
            check("m_valid", inst_valid, q_pc.size() != 0 && m_cause == 2'd0);
            if (q_pc.size() != 0 && inst_valid) begin
                check("m_inst", inst, q_data[0]);
                check("m_inst_pc", inst_pc, q_pc[0]);
            end
            check("m_err", fetch_err, m_cause != 2'd0);
            check("m_cause", err_cause, m_cause);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; merr = 1'b0;
        ready = 1'b0; rdata = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !mem_req; i++) tick();
        if (!mem_req) check("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic grant();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
    endtask

    task automatic respond(input logic [IW-1:0] d, input logic e);
        rvalid = 1'b1; rdata = d; merr = e;
        tick();
        rvalid = 1'b0; merr = 1'b0;
    endtask

    initial begin
        pc = '0;
        do_reset();
        check("rst_req", mem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_err", fetch_err, 0);
        check("rst_cause", err_cause, 0);

        // 1: basic fetch, latency from IDLE
        pc = 64'h8000_0000; en = 1'b1;
        tick();
        check("t1_req", mem_req, 1);
        check("t1_addr", mem_addr, 64'h8000_0000);
        grant();
        check("t1_novalid", inst_valid, 0);
        respond(32'h0000_0013, 1'b0);
        check("t1_valid_at3", inst_valid, 1);
        check("t1_inst", inst, 32'h0000_0013);
        check("t1_pc", inst_pc, 64'h8000_0000);

        // 2: backpressure, then back-to-back fetch
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", inst_valid, 1);
            check("t2_hold_inst", inst, 32'h0000_0013);
            check("t2_hold_noreq", mem_req, 0);
        end
        ready = 1'b1; pc = 64'h8000_0004;
        tick();
        ready = 1'b0;
        check("t2_req", mem_req, 1);
        check("t2_addr", mem_addr, 64'h8000_0004);
        grant();
        respond(32'h0010_0093, 1'b0);
        check("t2_inst", inst, 32'h0010_0093);
        check("t2_pc", inst_pc, 64'h8000_0004);
        ready = 1'b1; en = 1'b0;
        tick();
        ready = 1'b0;
        tick();
        check("t2_idle", mem_req, 0);

        // 3: flush while waiting for the response
        en = 1'b1; pc = 64'h8000_0008;
        wait_req();
        en = 1'b0;
        grant();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        respond(32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_novalid", inst_valid, 0);
        end
        en = 1'b1; pc = 64'h8000_000C;
        tick();
        check("t3_idle_restart", mem_req, 1);

        // 4: misaligned PC
        do_reset();
        pc = 64'h8000_0002; en = 1'b1;
        tick();
        check("t4_err", fetch_err, 1);
        check("t4_cause", err_cause, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_noreq", mem_req, 0);
            check("t4_sticky", err_cause, 2);
        end
        do_reset();
        check("t4_rst_cause", err_cause, 0);

        // 5a: bus error response
        en = 1'b1; pc = 64'h8000_0010;
        wait_req();
        en = 1'b0;
        grant();
        respond(32'h1234_5678, 1'b1);
        check("t5_bus_cause", err_cause, 1);
        check("t5_bus_novalid", inst_valid, 0);
        tick();
        check("t5_bus_sticky", fetch_err, 1);

        // 5b: timeout, then a late response is ignored
        do_reset();
        en = 1'b1; pc = 64'h8000_0020;
        wait_req();
        en = 1'b0;
        grant();
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (i == TO - 1) check("t5_to_early", fetch_err, 0);
        end
        check("t5_to_err", fetch_err, 1);
        check("t5_to_cause", err_cause, 3);
        respond(32'h0000_0013, 1'b0);
        tick();
        check("t5_late_novalid", inst_valid, 0);
        check("t5_late_cause", err_cause, 3);

        // 6: reset in WAIT with a stale response afterwards
        do_reset();
        en = 1'b1; pc = 64'h8000_0040;
        wait_req();
        en = 1'b0;
        grant();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        respond(32'hCAFE_F00D, 1'b0);
        tick();
        check("t6_req", mem_req, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_valid", inst_valid, 0);
        check("t6_inst", inst, 0);
        check("t6_pc", inst_pc, 0);
        check("t6_err", fetch_err, 0);
        check("t6_cause", err_cause, 0);

        // flush in REQ without grant withdraws the request
        en = 1'b1; pc = 64'h8000_0050;
        wait_req();
        en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t7_withdrawn", mem_req, 0);
        tick();
        check("t7_idle", mem_req, 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
